// File: rtl/seq_arith_pkg.sv
// rtl/seq_arith_pkg.sv - shared state encodings and sizing for the sequential arithmetic blocks
package seq_arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Iteration counter width; never narrower than one bit.
  function automatic int seq_cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

  localparam int DEFAULT_CNT_WIDTH = seq_cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_mul_add.sv
// rtl/seq_mul_add.sv - radix-2 shift-and-add multiply-accumulate, P = A*B + C, one bit per clock
module seq_mul_add
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   C,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int CW = seq_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;
  logic               last;

  assign last     = (cnt == LAST);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign busy     = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      P       <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= {{WIDTH{1'b0}}, C};
            cnt    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          // The final add is folded straight into P so the result lands on the WIDTH-th edge.
          if (last) begin
            P    <= acc_next;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_mul_add.md
# seq_mul_add

Sequential radix-2 shift-and-add multiply-accumulate unit computing P = A*B + C, one multiplier bit per clock. It is the inverse companion of the slow divider: given a quotient, divisor and remainder, it rebuilds the dividend. Typical use is as a round-trip self-check, with Q*Dr + R fed back against Nr. It uses the same start/done handshake as the divider, so one controller or bench can drive either block.

## Interface
- WIDTH, 4: operand width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- A  input  WIDTH  multiplicand (divisor role); unsigned.
- B  input  WIDTH  multiplier (quotient role); unsigned.
- C  input  WIDTH  addend (remainder role); unsigned, zero-extended.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle completion pulse.
- P  output  2*WIDTH  result; holds its value until the next completion.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
- IDLE with start=1 at an edge:
  - Latch A into the multiplicand register, zero-extended to 2*WIDTH.
  - Latch B into the multiplier shift register.
  - Load the accumulator with C, zero-extended.
  - Clear the iteration counter.
  - Go to RUN, set busy=1.
- Each RUN edge:
  - If multiplier LSB = 1, accumulator += multiplicand. Addition is modulo 2^(2*WIDTH).
  - Shift the multiplicand left 1 and the multiplier right 1.
  - Increment the counter.
- On the WIDTH-th RUN edge (counter = WIDTH-1):
  - P <= final accumulator value, including that edge's add.
  - done <= 1, busy <= 0.
  - State goes to IDLE.
- Overflow is impossible: the maximum result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W.
- A, B and C are read only at the accepting edge. Later changes do not affect the operation in flight.
- start while busy=1 is ignored. It is not queued.
- Reset, asynchronous, at any time including mid-RUN:
  - State goes to IDLE.
  - busy=0, done=0, P=0.
  - All internal registers are cleared.
  - The operation in flight is abandoned, and the next start behaves normally.

## Timing
- Accept edge: edge 0. busy is high after edge 0 through edge WIDTH.
- done is high for exactly the cycle after edge WIDTH, then low after edge WIDTH+1 unless a new operation completes. P is valid from edge WIDTH onward.
- Latency from accept edge to done: WIDTH cycles (4 at default).
- Back-to-back: start held during the done cycle is accepted at edge WIDTH+1, giving a throughput of one result per WIDTH+1 cycles.
- start held high continuously starts a new operation at every idle edge.
- Reset values: busy=0, done=0, P=0.

## Structure
- Shared package `seq_arith_pkg` holds:
  - state encodings (IDLE, RUN), shared with the divider;
  - default WIDTH constant;
  - counter width as clog2(WIDTH).
- There is no sub-module. Datapath (accumulator, shift registers, adder) and the two-state FSM live in one module.
- Counter is clog2(WIDTH) bits wide, minimum 1.

## Test plan
- Reset released, then A=2, B=3, C=1, start pulsed for one cycle -> busy for 4 cycles, then done pulses once with P=7. Inputs then changed while idle -> P stays 7.
- A=5, B=2, C=4 -> P=14. In the done cycle, start with A=15, B=15, C=15 -> accepted immediately, P=240 after 4 more cycles.
- A=0, B=9, C=0 -> P=0 with done pulse. Also A=7, B=0, C=6 -> P=6.
- Mid-operation: A, B and C changed and start re-asserted on cycle 2 of RUN -> ignored; result uses the original operands and exactly one done pulse occurs.
- reset asserted on RUN cycle 2 -> busy=0, done=0, P=0 immediately with no done pulse. A new start with A=3, B=3, C=2 -> P=11.
- Random sweep of all 4096 (A,B,C) combinations at WIDTH=4 -> P = A*B + C each time, with exactly one done pulse per accepted start.
